// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a five-stage RISC-V pipeline, with a memory-wait FSM and timeout.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             ID_UsesRs1,
    input  logic             ID_UsesRs2,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Bubble,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic             mem_fault
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              mem_op;
    logic              load_use;
    logic              mem_stall;
    logic              timeout;

    assign mem_op   = MEM_MemRead | MEM_MemWrite;
    assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                      ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                       (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        mem_stall     = 1'b0;
        timeout       = 1'b0;
        dmem_req      = 1'b0;
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        EX_MEM_Write  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        MEM_WB_Bubble = 1'b0;

        if (!rst_n) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            IF_ID_Flush   = 1'b1;
            ID_EX_Flush   = 1'b1;
            MEM_WB_Bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_op) begin
                        dmem_req = 1'b1;
                        if (!dmem_ready) begin
                            mem_stall    = 1'b1;
                            state_nxt    = MEM_WAIT;
                            wait_cnt_nxt = '0;
                        end
                    end
                end
                MEM_WAIT: begin
                    // Timeout is decided from the counter alone, keeping dmem_ready off the dmem_req path.
                    if (wait_cnt == WAIT_LAST) begin
                        timeout       = 1'b1;
                        MEM_WB_Bubble = 1'b1;
                        state_nxt     = RUN;
                    end else begin
                        dmem_req = 1'b1;
                        if (dmem_ready) begin
                            state_nxt = RUN;
                        end else begin
                            mem_stall    = 1'b1;
                            wait_cnt_nxt = wait_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = RUN;
            endcase

            if (mem_stall) begin
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Write  = 1'b0;
                MEM_WB_Bubble = 1'b1;
            end else if (EX_BranchTaken) begin
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end else if (load_use) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout) begin
                mem_fault <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_stall;
    logic br_flush;

    assign lu_stall = !mem_stall && !EX_BranchTaken && load_use;
    assign br_flush = !mem_stall && EX_BranchTaken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (mem_stall || lu_stall) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (br_flush) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected controls, a monitor compares mid-cycle.
// Counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] ID_Rs1, ID_Rs2, EX_Rd;
    logic ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken;
    logic MEM_MemRead, MEM_MemWrite, dmem_ready;
    logic dmem_req, PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, mem_fault;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    pipeline_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
        .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .ID_EX_Write(ID_EX_Write), .EX_MEM_Write(EX_MEM_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .MEM_WB_Bubble(MEM_WB_Bubble),
`ifdef HAZARD_PERF_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    // Expected vector: {dmem_req, PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
    //                   IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, mem_fault}
    localparam logic [8:0] RST    = 9'b0_0000_11_1_0;
    localparam logic [8:0] RSTF   = 9'b0_0000_11_1_1;
    localparam logic [8:0] ADV    = 9'b0_1111_00_0_0;
    localparam logic [8:0] ADVF   = 9'b0_1111_00_0_1;
    localparam logic [8:0] LU     = 9'b0_0011_01_0_0;
    localparam logic [8:0] LUF    = 9'b0_0011_01_0_1;
    localparam logic [8:0] BR     = 9'b0_1111_11_0_0;
    localparam logic [8:0] MST    = 9'b1_0000_00_1_0;
    localparam logic [8:0] MREL   = 9'b1_1111_00_0_0;
    localparam logic [8:0] MRELBR = 9'b1_1111_11_0_0;
    localparam logic [8:0] TOUT   = 9'b0_1111_00_1_0;

    int total = 0;
    int bad   = 0;
    int vec_idx = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the controls the DUT must show during that cycle.
    task automatic vec(input logic rst, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] exrd,
                       input logic exmr, input logic br, input logic mr, input logic mw,
                       input logic rdy, input logic [8:0] e);
        rst_n = rst; ID_Rs1 = rs1; ID_UsesRs1 = u1; ID_Rs2 = rs2; ID_UsesRs2 = u2;
        EX_Rd = exrd; EX_MemRead = exmr; EX_BranchTaken = br;
        MEM_MemRead = mr; MEM_MemWrite = mw; dmem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [8:0] e);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic reset_cycle(input logic [8:0] e);
        vec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [8:0] e;
            logic [8:0] act;
            e   = exp_q.pop_front();
            act = {dmem_req, PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                   IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, mem_fault};
            check($sformatf("ctrl[%0d]", vec_idx), 32'(act), 32'(e));
            vec_idx++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ID_Rs1 = '0; ID_Rs2 = '0; EX_Rd = '0; ID_UsesRs1 = 1'b0; ID_UsesRs2 = 1'b0;
        EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;

        reset_cycle(RST);
        reset_cycle(RST);
        idle(ADV);

        // Load x5 in EX, ID reads x5 via rs2: one stall cycle, then normal.
        vec(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        vec(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ADV);
        // x0 never hazards.
        vec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ADV);
        // Match via rs1, and a match on an unused source.
        vec(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        vec(1'b1, 5'd7, 1'b0, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ADV);
        // Branch overrides load-use; branch alone.
        vec(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BR);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BR);
        idle(ADV);

        // Store with ready three cycles after the first request.
        for (int i = 0; i < 3; i++)
            vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MST);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, MREL);
        // Back-to-back: zero-wait load, then a one-wait load requesting straight from RUN.
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, MREL);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MST);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, MREL);
        idle(ADV);

        // Taken branch and load-use held during a memory stall; branch applied on release.
        vec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, MST);
        vec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, MST);
        vec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, MRELBR);
        idle(ADV);

        // Load that never completes: 1 RUN cycle + 15 wait cycles, then timeout.
        for (int i = 0; i < 16; i++)
            vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MST);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, TOUT);
        idle(ADVF);
        vec(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LUF);
        idle(ADVF);
        reset_cycle(RSTF);
        reset_cycle(RST);

        // Reset during MEM_WAIT drops the request immediately.
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MST);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MST);
        vec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RST);
        idle(ADV);

`ifdef HAZARD_PERF_EN
        reset_cycle(RST);
        check("perf_reset_stall", stall_cycles, 32'd0);
        check("perf_reset_flush", flush_count, 32'd0);
        vec(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        idle(ADV);
        vec(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        for (int i = 0; i < 3; i++)
            vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MST);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, MREL);
        check("perf_stall_cycles", stall_cycles, 32'd5);
        vec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BR);
        idle(ADV);
        check("perf_flush_count", flush_count, 32'd1);
        check("perf_stall_hold", stall_cycles, 32'd5);
        reset_cycle(RST);
        check("perf_clear_stall", stall_cycles, 32'd0);
        check("perf_clear_flush", flush_count, 32'd0);
`endif

        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
